// File: rtl/stream_writer.sv
// Stream writer: buffers an AXI4S input stream in chunks, issues one write
// request per chunk, forwards the chunk on the send stream, then reports the
// byte count once all write completions for the buffer have returned.

package stream_writer_pkg;
    localparam int AXI_DATA_BITS  = 512;
    localparam int AXI_DATA_BYTES = AXI_DATA_BITS / 8;
    localparam int VADDR_BITS     = 48;
    localparam int LEN_BITS       = 28;
    localparam int PID_BITS       = 6;
    localparam int DEST_BITS      = 4;
    localparam int STRM_BITS      = 2;
    localparam int OPCODE_BITS    = 5;

    localparam logic [STRM_BITS-1:0] STRM_CARD = 2'd0;
    localparam logic [STRM_BITS-1:0] STRM_HOST = 2'd1;
    localparam logic [STRM_BITS-1:0] STRM_TCP  = 2'd2;
    localparam logic [STRM_BITS-1:0] STRM_RDMA = 2'd3;

    localparam logic [OPCODE_BITS-1:0] LOCAL_WRITE = 5'h02;
    localparam logic [OPCODE_BITS-1:0] RDMA_WRITE  = 5'h08;

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [STRM_BITS-1:0]   strm;
        logic                   mode;
        logic                   rdma;
        logic                   remote;
        logic [3:0]             vfid;
        logic [PID_BITS-1:0]    pid;
        logic [DEST_BITS-1:0]   dest;
        logic                   last;
        logic [VADDR_BITS-1:0]  vaddr;
        logic [LEN_BITS-1:0]    len;
        logic                   actv;
        logic                   host;
        logic [5:0]             offs;
    } req_t;
endpackage

module stream_writer
    import stream_writer_pkg::*;
#(
    parameter logic [STRM_BITS-1:0] STRM        = STRM_HOST,
    parameter logic [DEST_BITS-1:0] AXI_STRM_ID = '0,
    parameter bit                   IS_LOCAL    = 1'b1,
    parameter int TRANSFER_LENGTH_BYTES         = 4096,
    parameter int MAX_OUTSTANDING               = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_config_valid,
    output logic                      mem_config_ready,
    input  logic [VADDR_BITS-1:0]     mem_config_vaddr,
    input  logic [31:0]               mem_config_size,
    input  logic [AXI_DATA_BITS-1:0]  in_tdata,
    input  logic [AXI_DATA_BYTES-1:0] in_tkeep,
    input  logic                      in_tlast,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    output logic                      sq_wr_valid,
    input  logic                      sq_wr_ready,
    output req_t                      sq_wr_data,
    input  logic                      cq_wr_valid,
    input  req_t                      cq_wr_data,
    output logic                      cq_wr_ready,
    output logic [AXI_DATA_BITS-1:0]  out_tdata,
    output logic [AXI_DATA_BYTES-1:0] out_tkeep,
    output logic                      out_tlast,
    output logic [PID_BITS-1:0]       out_tid,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic                      status_valid,
    input  logic                      status_ready,
    output logic [31:0]               status_bytes,
    output logic                      status_last
);

    // FIFO holds exactly one chunk worth of full beats
    localparam int DEPTH  = TRANSFER_LENGTH_BYTES / AXI_DATA_BYTES;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] XFER_BYTES = 32'(TRANSFER_LENGTH_BYTES);

    typedef enum logic [2:0] {
        IDLE, COLLECT, REQUEST, SEND, FLUSH, REPORT
    } state_t;

    state_t state_reg, state_next;

    logic [VADDR_BITS-1:0]     vaddr_reg;
    logic [31:0]               remaining_reg;
    logic [31:0]               byte_total_reg;
    logic [31:0]               chunk_bytes_reg;
    logic                      stream_end_reg;
    logic [OUT_W-1:0]          outstanding_reg;
    logic [ADDR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]          fifo_count_reg;
    logic                      out_valid_reg;
    logic                      out_last_reg;
    logic [AXI_DATA_BITS-1:0]  out_data_reg;
    logic [AXI_DATA_BYTES-1:0] out_keep_reg;

    logic [AXI_DATA_BITS-1:0]  data_mem [DEPTH];
    logic [AXI_DATA_BYTES-1:0] keep_mem [DEPTH];

    logic [31:0] chunk_limit;
    logic [31:0] beat_bytes;
    logic [31:0] chunk_bytes_sum;
    logic        fifo_full;
    logic        in_accept;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        sq_fire;
    logic        out_fire;
    logic        cpl_match;
    logic        cpl_dec;
    logic        cpl_unused;

    assign chunk_limit     = (remaining_reg < XFER_BYTES) ? remaining_reg : XFER_BYTES;
    assign fifo_full       = (fifo_count_reg == CNT_W'(DEPTH));
    assign beat_bytes      = 32'($countones(in_tkeep));
    assign chunk_bytes_sum = chunk_bytes_reg + beat_bytes;

    assign mem_config_ready = (state_reg == IDLE);
    assign in_tready        = (state_reg == COLLECT) && !fifo_full && (chunk_bytes_reg < chunk_limit);
    assign in_accept        = in_tvalid && in_tready;
    // Empty-keep beats carry no data; only their tlast matters
    assign fifo_wr          = in_accept && (in_tkeep != '0);

    assign sq_wr_valid = (state_reg == REQUEST) && (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
    assign sq_fire     = sq_wr_valid && sq_wr_ready;

    assign fifo_rd  = (state_reg == SEND) && (fifo_count_reg != '0) && (!out_valid_reg || out_tready);
    assign out_fire = out_valid_reg && out_tready;

    assign cq_wr_ready = 1'b1;
    assign cpl_match   = cq_wr_valid && (cq_wr_data.strm == STRM) && (cq_wr_data.dest == AXI_STRM_ID);
    // Stale completions (e.g. after a reset) must not wrap the counter
    assign cpl_dec     = cpl_match && (outstanding_reg != '0);
    assign cpl_unused  = ^cq_wr_data;

    assign out_tvalid = out_valid_reg;
    assign out_tdata  = out_data_reg;
    assign out_tkeep  = out_keep_reg;
    assign out_tlast  = out_last_reg;
    assign out_tid    = '0;

    assign status_valid = (state_reg == REPORT);
    assign status_bytes = byte_total_reg;
    assign status_last  = stream_end_reg;

    // Write request for the chunk currently held in the FIFO
    always_comb begin
        sq_wr_data        = '0;
        sq_wr_data.opcode = IS_LOCAL ? LOCAL_WRITE : RDMA_WRITE;
        sq_wr_data.mode   = !IS_LOCAL;
        sq_wr_data.rdma   = !IS_LOCAL;
        sq_wr_data.remote = !IS_LOCAL;
        sq_wr_data.strm   = STRM;
        sq_wr_data.dest   = AXI_STRM_ID;
        sq_wr_data.pid    = '0;
        sq_wr_data.vaddr  = vaddr_reg;
        sq_wr_data.len    = LEN_BITS'(chunk_bytes_reg);
        sq_wr_data.last   = 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (mem_config_valid) state_next = COLLECT;
            COLLECT: if (in_accept && (in_tlast || chunk_bytes_sum >= chunk_limit))
                         state_next = (chunk_bytes_sum == '0) ? FLUSH : REQUEST;
            REQUEST: if (sq_fire) state_next = SEND;
            SEND:    if (out_fire && out_last_reg)
                         state_next = (stream_end_reg || remaining_reg == '0) ? FLUSH : COLLECT;
            FLUSH:   if (outstanding_reg == '0) state_next = REPORT;
            REPORT:  if (status_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, descriptor bookkeeping, FIFO pointers and outstanding counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            vaddr_reg       <= '0;
            remaining_reg   <= '0;
            byte_total_reg  <= '0;
            chunk_bytes_reg <= '0;
            stream_end_reg  <= 1'b0;
            outstanding_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fifo_count_reg  <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && mem_config_valid) begin
                vaddr_reg       <= mem_config_vaddr;
                remaining_reg   <= mem_config_size;
                byte_total_reg  <= '0;
                chunk_bytes_reg <= '0;
                stream_end_reg  <= 1'b0;
            end

            if (in_accept) begin
                chunk_bytes_reg <= chunk_bytes_sum;
                if (in_tlast) stream_end_reg <= 1'b1;
            end

            if (sq_fire) begin
                vaddr_reg      <= vaddr_reg + VADDR_BITS'(chunk_bytes_reg);
                remaining_reg  <= remaining_reg - chunk_bytes_reg;
                byte_total_reg <= byte_total_reg + chunk_bytes_reg;
            end

            if (state_reg == SEND && out_fire && out_last_reg)
                chunk_bytes_reg <= '0;

            if (fifo_wr)
                wr_ptr_reg <= (wr_ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (fifo_rd)
                rd_ptr_reg <= (rd_ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            fifo_count_reg <= fifo_count_reg + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

            if (fifo_rd) begin
                out_valid_reg <= 1'b1;
                out_last_reg  <= (fifo_count_reg == CNT_W'(1));
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            unique case ({sq_fire, cpl_dec})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Chunk storage with registered read into the output stage
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            data_mem[wr_ptr_reg] <= in_tdata;
            keep_mem[wr_ptr_reg] <= in_tkeep;
        end
        if (fifo_rd) begin
            out_data_reg <= data_mem[rd_ptr_reg];
            out_keep_reg <= keep_mem[rd_ptr_reg];
        end
    end

    // Input keep must be contiguous from lane 0
    generate
        for (genvar gi = 1; gi < AXI_DATA_BYTES; gi++) begin : g_keep_chk
            a_keep_contig: assert property (@(posedge clk) disable iff (rst)
                (in_tvalid && in_tready && in_tkeep[gi]) |-> in_tkeep[gi-1]);
        end
    endgenerate

    a_keep_full: assert property (@(posedge clk) disable iff (rst)
        (in_tvalid && in_tready && !in_tlast) |-> (&in_tkeep));

    a_cfg_size: assert property (@(posedge clk) disable iff (rst)
        (mem_config_valid && mem_config_ready) |->
        (mem_config_size != '0 && (mem_config_size % AXI_DATA_BYTES) == 0));

endmodule

// File: doc/stream_writer.md
Name: stream_writer

Overview:
- Downstream counterpart of the stream reader; it is the sink that writes a processed AXI4S stream back into a host or card buffer through Coyote's sq_wr/cq_wr queues.
- Collects up to TRANSFER_LENGTH_BYTES of input into an internal FIFO, then issues one sq_wr request carrying the exact collected length, then forwards those beats on the Coyote send stream.
- After the buffer is exhausted or the input tlast is seen, waits for all write completions and reports the byte count on a status handshake.

Parameters:
STRM, STRM_HOST, Coyote stream type placed in requests and matched on completions
AXI_STRM_ID, 0, dest/stream id placed in requests and matched on completions
IS_LOCAL, 1, 1: LOCAL_WRITE opcode; 0: RDMA_WRITE (opcode 8), with mode/rdma/remote set
TRANSFER_LENGTH_BYTES, 4096, max bytes per sq_wr request; multiple of AXI_DATA_BYTES
MAX_OUTSTANDING, 4, max issued-but-uncompleted requests (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_config_valid  in  1  buffer descriptor valid
mem_config_ready  out  1  accepting descriptor
mem_config_vaddr  in  VADDR_BITS  buffer start address
mem_config_size  in  32  buffer bytes; >0 and multiple of AXI_DATA_BYTES
in_tdata/in_tkeep/in_tlast  in  AXI_DATA_BITS/AXI_DATA_BITS/8/1  input stream
in_tvalid  in  1 / in_tready  out  1  input handshake
sq_wr_valid  out  1 / sq_wr_ready  in  1 / sq_wr_data  out  $bits(req_t)  write request
cq_wr_valid  in  1 / cq_wr_data  in  $bits(req_t) / cq_wr_ready  out  1  completions; ready tied 1
out_tdata/out_tkeep/out_tlast/out_tid  out  AXI_DATA_BITS/AXI_DATA_BITS/8/1/PID_BITS  send stream; tid=0
out_tvalid  out  1 / out_tready  in  1
status_valid  out  1 / status_ready  in  1  report handshake
status_bytes  out  32  bytes written into this buffer
status_last  out  1  1: input tlast ended the stream; 0: buffer filled first

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, FIFO empty, outstanding=0, counters 0.
- Output values in reset and IDLE: all valid outputs 0, in_tready=0, mem_config_ready=1.
- In-flight completions that arrive after reset are ignored. The outstanding counter never underflows.
- IDLE: mem_config_ready=1. On valid, latch vaddr and remaining=size, clear byte_total and stream_end, then go to COLLECT.
- COLLECT:
  - chunk_limit = min(remaining, TRANSFER_LENGTH_BYTES).
  - in_tready = FIFO not full && chunk_bytes < chunk_limit.
  - Each accepted beat adds countones(tkeep) to chunk_bytes.
  - A beat with tkeep=0 is dropped, but its tlast is still honoured.
  - On acceptance of a tlast beat, or when chunk_bytes reaches chunk_limit: set stream_end if tlast, then go to REQUEST on the next cycle. If chunk_bytes==0, go to FLUSH instead.
- REQUEST:
  - sq_wr_valid=1 while outstanding<MAX_OUTSTANDING.
  - Request fields: opcode, strm, dest=AXI_STRM_ID, pid=0, vaddr, len=chunk_bytes, last=1; all other fields 0.
  - On handshake: vaddr+=chunk_bytes, remaining-=chunk_bytes, byte_total+=chunk_bytes, outstanding++, go to SEND.
- SEND:
  - FIFO drains to out_*. out_tlast=1 on the beat that empties the FIFO.
  - After that beat: go to FLUSH if stream_end or remaining==0; otherwise clear chunk_bytes and go to COLLECT.
- FLUSH: wait until outstanding==0, then go to REPORT.
- REPORT: status_valid=1 with status_bytes=byte_total and status_last=stream_end. On handshake go to IDLE.
- Completion match: cq_wr_valid && data.strm==STRM && data.dest==AXI_STRM_ID; a match decrements outstanding. Opcode is not checked. An increment and a decrement in the same cycle leave outstanding unchanged.
- Buffer full without tlast: status_last=0. Input stays stalled until the next descriptor, and the stream continues into the new buffer.
- Assertions: tkeep contiguous from LSB; non-last tkeep all ones; mem_config_size>0 and aligned.

Test Plan:
1. Stream setup: AXI 64 B beats; size=8192 at 0x1000; 128 full beats, tlast on beat 128 -> sq_wr len 4096 @0x1000 then len 4096 @0x2000. Out: 64 beats per chunk, tlast on beats 64 and 128. After 2 completions: status bytes=8192, last=1.
2. size=8192; 10 beats, final tkeep=0xFF -> one request, len=584. Status bytes=584, last=1.
3. size=4096; 100 beats without tlast -> one request of 4096. Status bytes=4096, last=0. in_tready stays 0 after beat 64 until a new descriptor at 0x9000; then the remaining 36 beats go out as len 2304 @0x9000.
4. MAX_OUTSTANDING=1, completions withheld -> second sq_wr_valid held 0. It rises the cycle after a matching cq_wr.
5. Completion with dest=AXI_STRM_ID+1 -> ignored; FLUSH holds. A match arriving in the same cycle as a request handshake leaves outstanding at 1.
6. rst asserted mid-SEND with 20 beats in the FIFO -> next cycle all valids are 0 and mem_config_ready=1. A subsequent 4096 B buffer is written correctly.
